// File: rtl/gc_joybus_poller.sv
// Joybus host for one GameCube controller port: sends the 24-bit poll command on the
// open-drain line, then decodes the controller's 64-bit reply into a parallel word.
module gc_joybus_poller #(
    parameter int CLK_PER_US     = 60,
    parameter int RX_TIMEOUT_US  = 100,
    parameter int BIT_TIMEOUT_US = 8,
    parameter int GLITCH_CYC     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rumble,
    input  logic        line_in,
    output logic        line_oe,
    output logic        busy,
    output logic [63:0] data,
    output logic        valid,
    output logic        err
);
    // Handshake: start is sampled only while idle; valid and err are single-cycle
    // strobes issued in the same cycle that busy falls, and data changes only with valid.

    localparam logic [15:0] T_SHORT = 16'(CLK_PER_US);
    localparam logic [15:0] T_LONG  = 16'(3 * CLK_PER_US);
    localparam logic [15:0] T_CELL  = 16'(4 * CLK_PER_US);
    localparam logic [15:0] THRESH  = 16'(2 * CLK_PER_US);
    localparam logic [15:0] RX_TO   = 16'(RX_TIMEOUT_US * CLK_PER_US);
    localparam logic [15:0] BIT_TO  = 16'(BIT_TIMEOUT_US * CLK_PER_US);
    localparam logic [15:0] GLITCH  = 16'(GLITCH_CYC);

    typedef enum logic [3:0] {
        IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_LOW, RX_HIGH, RX_STOP, DONE, ERR
    } state_t;

    state_t      state, state_n, prev, prev_n;
    logic [1:0]  sync;
    logic        ls;
    logic [23:0] cmd;
    logic [4:0]  bit_idx;
    logic [6:0]  rx_bits;
    logic [63:0] shreg;
    logic [15:0] tmr, low_cnt, low_len, hi_len;
    logic        cur_bit, rx_bit;
    logic        tmr_clr, tmr_one, low_start, load_cmd, idx_dec, shift_en;

    assign ls      = sync[1];
    assign cur_bit = cmd[bit_idx];
    assign low_len = cur_bit ? T_SHORT : T_LONG;
    assign hi_len  = T_CELL - low_len;
    assign rx_bit  = (low_cnt < THRESH);

    assign line_oe = (state == TX_LOW) || (state == TX_STOP);
    assign busy    = (state != IDLE) && (state != DONE) && (state != ERR);
    assign valid   = (state == DONE);
    assign err     = (state == ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prev  <= RX_WAIT;
        end else begin
            state <= state_n;
            prev  <= prev_n;
        end
    end

    always_comb begin
        state_n   = state;
        prev_n    = prev;
        tmr_clr   = 1'b0;
        tmr_one   = 1'b0;
        low_start = 1'b0;
        load_cmd  = 1'b0;
        idx_dec   = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = TX_LOW;
                    load_cmd = 1'b1;
                    tmr_clr  = 1'b1;
                end
            end
            TX_LOW: begin
                if (tmr == low_len - 16'd1) begin
                    state_n = TX_HIGH;
                    tmr_clr = 1'b1;
                end
            end
            TX_HIGH: begin
                if (tmr == hi_len - 16'd1) begin
                    tmr_clr = 1'b1;
                    if (bit_idx == 5'd0) begin
                        state_n = TX_STOP;
                    end else begin
                        idx_dec = 1'b1;
                        state_n = TX_LOW;
                    end
                end
            end
            TX_STOP: begin
                if (tmr == T_SHORT - 16'd1) begin
                    state_n = RX_WAIT;
                    tmr_clr = 1'b1;
                end
            end
            RX_WAIT: begin
                if (tmr >= RX_TO - 16'd1) begin
                    state_n = ERR;
                end else if (!ls) begin
                    state_n   = RX_LOW;
                    prev_n    = RX_WAIT;
                    low_start = 1'b1;
                end
            end
            RX_HIGH, RX_STOP: begin
                if (tmr >= BIT_TO - 16'd1) begin
                    state_n = ERR;
                end else if (!ls) begin
                    state_n   = RX_LOW;
                    prev_n    = state;
                    low_start = 1'b1;
                end
            end
            RX_LOW: begin
                // tmr keeps running here so a glitch cannot extend the waiting state's timeout
                if (ls) begin
                    if (low_cnt < GLITCH) begin
                        state_n = prev;
                    end else if (prev == RX_STOP) begin
                        state_n = DONE;
                    end else begin
                        shift_en = 1'b1;
                        tmr_one  = 1'b1;
                        state_n  = (rx_bits == 7'd63) ? RX_STOP : RX_HIGH;
                    end
                end else if (low_cnt >= BIT_TO - 16'd1) begin
                    state_n = ERR;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b11;
            cmd     <= '0;
            bit_idx <= '0;
            rx_bits <= '0;
            shreg   <= '0;
            tmr     <= '0;
            low_cnt <= '0;
            data    <= '0;
        end else begin
            sync <= {sync[0], line_in};

            if (tmr_clr)
                tmr <= '0;
            else if (tmr_one)
                tmr <= 16'd1;
            else if (tmr != 16'hFFFF)
                tmr <= tmr + 16'd1;

            // The cycle that first sees the line low counts as low cycle 1
            if (low_start)
                low_cnt <= 16'd1;
            else if (low_cnt != 16'hFFFF)
                low_cnt <= low_cnt + 16'd1;

            if (load_cmd) begin
                cmd     <= {8'h40, 8'h03, 7'h00, rumble};
                bit_idx <= 5'd23;
                rx_bits <= '0;
            end
            if (idx_dec)
                bit_idx <= bit_idx - 5'd1;
            if (shift_en) begin
                shreg   <= {shreg[62:0], rx_bit};
                rx_bits <= rx_bits + 7'd1;
            end
            if (state_n == DONE)
                data <= shreg;
        end
    end

endmodule
